// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port synchronous RAM between two bus masters. Master 0 is
//   the CPU and master 1 is a secondary requester such as a loader or debug port.
//   A level request from a master becomes one RAM access followed by a one-cycle
//   ack. When both masters request, the winner is chosen round-robin, or master 0
//   always wins if FIXED_PRIO=1.
//
//   Transaction sequence: IDLE -> ISSUE -> WAIT (RAM_LAT cycles) -> ACK -> IDLE.
//   Every output is a register.
//
// Parameters
//   AW, DW      address and data widths
//   RAM_LAT     cycles from ram_en to valid ram_rdata (1..4)
//   FIXED_PRIO  1 = master 0 wins ties, 0 = round-robin
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   mN_req/we/addr/wdata (N=0,1)    master request and command inputs
//   mN_ack, mN_rdata                completion pulse and read data
//   ram_en/we/addr/wdata            RAM command strobe and payload
//   ram_rdata                       RAM read data
//   busy                            high whenever a transaction is in flight

module mem_bus_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int RAM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  // wait_cnt counts down the remaining read-latency cycles. It reaches 0 in the
  // WAIT cycle in which ram_rdata becomes valid.
  localparam logic [1:0] WAIT_INIT = 2'(RAM_LAT - 1);

  state_t        state, state_d;
  logic          owner, owner_d;            // 0 = master 0 owns the access
  logic          last_grant, last_grant_d;
  logic [1:0]    wait_cnt, wait_cnt_d;
  logic          win_m1;

  logic          ram_en_d, ram_we_d, m0_ack_d, m1_ack_d, busy_d;
  logic [AW-1:0] ram_addr_d;
  logic [DW-1:0] ram_wdata_d, m0_rdata_d, m1_rdata_d;

  // NOTE: every signal written here is first given a default value, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_grant_d = last_grant;
    wait_cnt_d   = wait_cnt;
    ram_en_d     = 1'b0;
    ram_we_d     = ram_we;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata;
    m1_rdata_d   = m1_rdata;

    // Master 1 wins when it requests alone. On a tie it wins only under
    // round-robin, and only if master 0 was served last.
    win_m1 = m1_req && (!m0_req || (FIXED_PRIO == 0 && !last_grant));

    case (state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // ram_we/addr/wdata double as the latched command. Later changes
          // on the master bus cannot affect this access.
          owner_d     = win_m1;
          ram_en_d    = 1'b1;
          ram_we_d    = win_m1 ? m1_we    : m0_we;
          ram_addr_d  = win_m1 ? m1_addr  : m0_addr;
          ram_wdata_d = win_m1 ? m1_wdata : m0_wdata;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == 2'd0) begin
          if (!ram_we) begin
            if (owner) m1_rdata_d = ram_rdata;
            else       m0_rdata_d = ram_rdata;
          end
          m0_ack_d = !owner;
          m1_ack_d = owner;
          state_d  = S_ACK;
        end else begin
          wait_cnt_d = wait_cnt - 2'd1;
        end
      end
      S_ACK: begin
        last_grant_d = owner;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state is updated only with non-blocking assignments. Every register
  // then samples the values from before the clock edge, regardless of the
  // order of the statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= 2'd0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      wait_cnt   <= wait_cnt_d;
      ram_en     <= ram_en_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      m0_ack     <= m0_ack_d;
      m1_ack     <= m1_ack_d;
      m0_rdata   <= m0_rdata_d;
      m1_rdata   <= m1_rdata_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Three arbiter instances, each with its own behavioural RAM:
//     instance 0: RAM_LAT=1, round-robin
//     instance 1: RAM_LAT=1, fixed priority
//     instance 2: RAM_LAT=3, round-robin
//   A table of single-master transactions runs against instance 0. Hand-written
//   sequences cover arbitration order, latency, reset in flight and command
//   latching.

module tb_mem_bus_arbiter;

  localparam int N = 3;

  logic       clk;
  logic       rst       [N];
  logic       m0_req    [N];
  logic       m0_we     [N];
  logic [7:0] m0_addr   [N];
  logic [7:0] m0_wdata  [N];
  logic       m0_ack    [N];
  logic [7:0] m0_rdata  [N];
  logic       m1_req    [N];
  logic       m1_we     [N];
  logic [7:0] m1_addr   [N];
  logic [7:0] m1_wdata  [N];
  logic       m1_ack    [N];
  logic [7:0] m1_rdata  [N];
  logic       ram_en    [N];
  logic       ram_we    [N];
  logic [7:0] ram_addr  [N];
  logic [7:0] ram_wdata [N];
  logic [7:0] ram_rdata [N];
  logic       busy      [N];

  int n_checks = 0;
  int n_errors = 0;

  // Read data each master should currently hold, per instance.
  logic [7:0] shadow [N][2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int FP  = (g == 1) ? 1 : 0;

    logic [7:0] mem  [256];
    logic [7:0] pipe [4];

    mem_bus_arbiter #(.AW(8), .DW(8), .RAM_LAT(LAT), .FIXED_PRIO(FP)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .m0_req    (m0_req[g]),
      .m0_we     (m0_we[g]),
      .m0_addr   (m0_addr[g]),
      .m0_wdata  (m0_wdata[g]),
      .m0_ack    (m0_ack[g]),
      .m0_rdata  (m0_rdata[g]),
      .m1_req    (m1_req[g]),
      .m1_we     (m1_we[g]),
      .m1_addr   (m1_addr[g]),
      .m1_wdata  (m1_wdata[g]),
      .m1_ack    (m1_ack[g]),
      .m1_rdata  (m1_rdata[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g]),
      .busy      (busy[g])
    );

    // Synchronous RAM with a LAT-deep read pipeline. A cycle without a read
    // fills the pipeline with 0xEE, so a capture at the wrong time is visible.
    always @(posedge clk) begin
      if (ram_en[g] && ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
      pipe[0] <= (ram_en[g] && !ram_we[g]) ? mem[ram_addr[g]] : 8'hEE;
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata[g] = pipe[LAT-1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  function automatic logic get_ack(input int g, input int m);
    return (m == 1) ? m1_ack[g] : m0_ack[g];
  endfunction

  function automatic logic [7:0] get_rdata(input int g, input int m);
    return (m == 1) ? m1_rdata[g] : m0_rdata[g];
  endfunction

  task automatic set_req(input int g, input int m, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata);
    if (m == 1) begin
      m1_req[g] = req; m1_we[g] = we; m1_addr[g] = addr; m1_wdata[g] = wdata;
    end else begin
      m0_req[g] = req; m0_we[g] = we; m0_addr[g] = addr; m0_wdata[g] = wdata;
    end
  endtask

  // Run one transaction for one master. Call this at a negedge with the DUT
  // idle; that cycle is cycle 0. Returns at the negedge after the ack cycle.
  task automatic run_txn(input int g, input int m, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd, input string name);
    int n;
    bit got;
    set_req(g, m, 1'b1, we, addr, wdata);
    @(negedge clk);
    check({name, " ram_en"}, 32'(ram_en[g]), 32'd1);
    check({name, " ram_we"}, 32'(ram_we[g]), 32'(we));
    check({name, " ram_addr"}, 32'(ram_addr[g]), 32'(addr));
    if (we) check({name, " ram_wdata"}, 32'(ram_wdata[g]), 32'(wdata));
    check({name, " busy"}, 32'(busy[g]), 32'd1);
    n = 1;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (get_ack(g, m)) got = 1'b1;
    end
    check({name, " ack cycle"}, 32'(n), 32'(2 + lat_of(g)));
    check({name, " other ack"}, 32'(get_ack(g, 1 - m)), 32'd0);
    if (!we) shadow[g][m] = exp_rd;
    check({name, " rdata"}, 32'(get_rdata(g, m)), 32'(shadow[g][m]));
    check({name, " other rdata"}, 32'(get_rdata(g, 1 - m)), 32'(shadow[g][1-m]));
    set_req(g, m, 1'b0, we, addr, wdata);
    @(negedge clk);
    check({name, " ack drop"}, 32'(get_ack(g, m)), 32'd0);
    check({name, " idle busy"}, 32'(busy[g]), 32'd0);
    check({name, " idle ram_en"}, 32'(ram_en[g]), 32'd0);
  endtask

  task automatic do_reset(input int g);
    rst[g] = 1'b1;
    @(negedge clk);
    rst[g] = 1'b0;
    shadow[g][0] = 8'h00;
    shadow[g][1] = 8'h00;
  endtask

  typedef struct {
    int         m;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    int ack_cyc [4];
    int ack_m   [4];
    int n_ack, n0, n1, stray;

    vecs[0] = '{0, 1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{0, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1, 1'b1, 8'h20, 8'h5A, 8'h00};
    vecs[3] = '{1, 1'b0, 8'h20, 8'h00, 8'h5A};
    vecs[4] = '{0, 1'b0, 8'h20, 8'h00, 8'h5A};
    vecs[5] = '{1, 1'b1, 8'hFF, 8'h00, 8'h00};
    vecs[6] = '{1, 1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[7] = '{0, 1'b1, 8'h00, 8'hFF, 8'h00};
    vecs[8] = '{1, 1'b0, 8'h00, 8'h00, 8'hFF};
    vecs[9] = '{0, 1'b0, 8'h10, 8'h00, 8'hA5};

    for (int g = 0; g < N; g++) begin
      rst[g] = 1'b1;
      set_req(g, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(g, 1, 1'b0, 1'b0, 8'h00, 8'h00);
      shadow[g][0] = 8'h00;
      shadow[g][1] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < N; g++) rst[g] = 1'b0;

    // Reset state of every instance.
    for (int g = 0; g < N; g++) begin
      check($sformatf("reset%0d ram_en", g), 32'(ram_en[g]), 32'd0);
      check($sformatf("reset%0d busy", g), 32'(busy[g]), 32'd0);
      check($sformatf("reset%0d acks", g), 32'({m0_ack[g], m1_ack[g]}), 32'd0);
    end

    // Table of single-master transactions on instance 0.
    for (int i = 0; i < 10; i++)
      run_txn(0, vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
              $sformatf("vec%0d", i));

    // Round-robin with both requests rising together after reset: master 0
    // goes first, then the grants alternate.
    do_reset(0);
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin ack_cyc[i] = -1; ack_m[i] = -1; end
    set_req(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    set_req(0, 1, 1'b1, 1'b0, 8'h20, 8'h00);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (m0_ack[0] || m1_ack[0]) begin
        if (n_ack < 4) begin
          ack_cyc[n_ack] = c;
          ack_m[n_ack]   = m1_ack[0] ? 1 : 0;
        end
        n_ack++;
        if (m0_ack[0]) check("rr m0 rdata", 32'(m0_rdata[0]), 32'h0000_00A5);
        if (m1_ack[0]) check("rr m1 rdata", 32'(m1_rdata[0]), 32'h0000_005A);
      end
    end
    set_req(0, 0, 1'b0, 1'b0, 8'h10, 8'h00);
    set_req(0, 1, 1'b0, 1'b0, 8'h20, 8'h00);
    shadow[0][0] = 8'hA5;
    shadow[0][1] = 8'h5A;
    check("rr ack count", 32'(n_ack), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr ack%0d cycle", i), 32'(ack_cyc[i]), 32'(3 + 4 * i));
      check($sformatf("rr ack%0d master", i), 32'(ack_m[i]), 32'(i % 2));
    end
    @(negedge clk);
    check("rr final busy", 32'(busy[0]), 32'd0);

    // Fixed priority: master 0 takes every grant while both requests are held.
    n0 = 0;
    n1 = 0;
    set_req(1, 0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1, 1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (m0_ack[1]) n0++;
      if (m1_ack[1]) n1++;
    end
    set_req(1, 0, 1'b0, 1'b0, 8'h01, 8'h00);
    set_req(1, 1, 1'b0, 1'b0, 8'h02, 8'h00);
    check("fixed m0 acks", 32'(n0), 32'd4);
    check("fixed m1 acks", 32'(n1), 32'd0);
    @(negedge clk);

    // RAM_LAT=3: m1 reads back 0x3C from 0x7F. The ack comes in cycle 5.
    run_txn(2, 0, 1'b1, 8'h7F, 8'h3C, 8'h00, "lat3 wr");
    run_txn(2, 1, 1'b0, 8'h7F, 8'h00, 8'h3C, "lat3 rd");

    // Reset in the WAIT state of an m0 read abandons the access.
    set_req(0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    check("rstwait ram_en", 32'(ram_en[0]), 32'd1);
    @(negedge clk);
    rst[0] = 1'b1;
    set_req(0, 0, 1'b0, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    rst[0] = 1'b0;
    shadow[0][0] = 8'h00;
    shadow[0][1] = 8'h00;
    check("rstwait m0_ack", 32'(m0_ack[0]), 32'd0);
    check("rstwait ram_en0", 32'(ram_en[0]), 32'd0);
    check("rstwait ram_we", 32'(ram_we[0]), 32'd0);
    check("rstwait ram_addr", 32'(ram_addr[0]), 32'd0);
    check("rstwait ram_wdata", 32'(ram_wdata[0]), 32'd0);
    check("rstwait busy", 32'(busy[0]), 32'd0);
    check("rstwait m0_rdata", 32'(m0_rdata[0]), 32'd0);
    check("rstwait m1_rdata", 32'(m1_rdata[0]), 32'd0);
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (m0_ack[0] || m1_ack[0] || ram_en[0]) stray++;
    end
    check("rstwait stray activity", 32'(stray), 32'd0);
    run_txn(0, 0, 1'b0, 8'h20, 8'h00, 8'h5A, "post-rst rd");

    // m0 drops req and changes addr during WAIT; the latched access completes.
    set_req(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check("latch ram_addr c1", 32'(ram_addr[0]), 32'h10);
    check("latch busy c1", 32'(busy[0]), 32'd1);
    @(negedge clk);
    set_req(0, 0, 1'b0, 1'b0, 8'h55, 8'h00);
    check("latch busy c2", 32'(busy[0]), 32'd1);
    @(negedge clk);
    check("latch m0_ack c3", 32'(m0_ack[0]), 32'd1);
    check("latch m0_rdata", 32'(m0_rdata[0]), 32'h0000_00A5);
    check("latch ram_addr c3", 32'(ram_addr[0]), 32'h10);
    check("latch busy c3", 32'(busy[0]), 32'd1);
    @(negedge clk);
    check("latch m0_ack c4", 32'(m0_ack[0]), 32'd0);
    check("latch busy c4", 32'(busy[0]), 32'd0);
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m0_ack[0] || ram_en[0]) stray++;
    end
    check("latch no retrigger", 32'(stray), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
